uart_sched: RTL

Sequencer and buffer between the `uart` register interface (TX_RDY=0, TX_DAT=1, RX_RDY=2, RX_DAT=3) and client logic. It turns the UART's polled register interface into two valid/ready byte streams. It owns the UART's `i_en`/`i_wr`/`i_addr`/`i_data` inputs and schedules RX polling and TX writes fairly, so that neither direction starves the other. Each direction has a small FIFO.

---
 rtl/uart_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_sched.sv
// uart_sched: turns the polled UART register interface into two valid/ready
// byte streams. One FSM owns the UART bus and alternates fairly between RX
// polling and TX writes; each direction is buffered in a small FIFO.
module uart_sched #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_uart_en,
    output logic       o_uart_wr,
    output logic [3:0] o_uart_addr,
    output logic [7:0] o_uart_wdata,
    input  logic [7:0] i_uart_rdata,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_rx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // UART register map
    localparam logic [3:0] ADDR_TX_RDY = 4'd0;
    localparam logic [3:0] ADDR_TX_DAT = 4'd1;
    localparam logic [3:0] ADDR_RX_RDY = 4'd2;
    localparam logic [3:0] ADDR_RX_DAT = 4'd3;

    // Direction served most recently; decides the winner when both are eligible
    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RX_POLL,
        RX_CHK,
        RX_READ,
        RX_CAP,
        TX_POLL,
        TX_CHK,
        TX_WRITE
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign tx_full  = (tx_wptr[DEPTH_LOG2] != tx_rptr[DEPTH_LOG2]) &&
                      (tx_wptr[DEPTH_LOG2-1:0] == tx_rptr[DEPTH_LOG2-1:0]);
    assign tx_empty = (tx_wptr == tx_rptr);
    assign rx_full  = (rx_wptr[DEPTH_LOG2] != rx_rptr[DEPTH_LOG2]) &&
                      (rx_wptr[DEPTH_LOG2-1:0] == rx_rptr[DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);

    // Ready is held low during reset; a same-cycle FSM pop does not make room
    assign o_tx_ready = !tx_full && !i_rst;
    assign o_rx_valid = !rx_empty;
    assign o_rx_data  = rx_mem[rx_rptr[DEPTH_LOG2-1:0]];
    assign tx_head    = tx_mem[tx_rptr[DEPTH_LOG2-1:0]];

    assign tx_push = i_tx_valid && o_tx_ready;
    assign tx_pop  = (state == TX_WRITE);
    assign rx_push = (state == RX_CAP);
    assign rx_pop  = o_rx_valid && i_rx_ready;

    // FIFO storage writes
    // NOTE: storage arrays carry no reset; emptiness is defined by the pointers,
    // so clearing the data would only cost flops and routing.
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wptr[DEPTH_LOG2-1:0]] <= i_tx_data;
        if (rx_push) rx_mem[rx_wptr[DEPTH_LOG2-1:0]] <= i_uart_rdata;
    end

    // FIFO pointer updates; reset discards any buffered bytes
    // NOTE: non-blocking assignments here so every register samples pre-edge
    // values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
        end
    end

    // FSM state and fairness register; last starts at TX so RX is served first
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            last  <= DIR_TX;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, then walk one poll/transfer sequence
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (!rx_full && !tx_empty)
                    state_nxt = (last == DIR_TX) ? RX_POLL : TX_POLL;
                else if (!rx_full)
                    state_nxt = RX_POLL;
                else if (!tx_empty)
                    state_nxt = TX_POLL;
            end
            RX_POLL: state_nxt = RX_CHK;
            RX_CHK: begin
                if (i_uart_rdata != 8'h00) begin
                    state_nxt = RX_READ;
                end else begin
                    state_nxt = IDLE;
                    last_nxt  = DIR_RX;
                end
            end
            RX_READ: state_nxt = RX_CAP;
            RX_CAP: begin
                state_nxt = IDLE;
                last_nxt  = DIR_RX;
            end
            TX_POLL: state_nxt = TX_CHK;
            TX_CHK: begin
                if (i_uart_rdata != 8'h00) begin
                    state_nxt = TX_WRITE;
                end else begin
                    state_nxt = IDLE;
                    last_nxt  = DIR_TX;
                end
            end
            TX_WRITE: begin
                state_nxt = IDLE;
                last_nxt  = DIR_TX;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // UART bus decode, driven from the state register only
    always_comb begin
        o_uart_en    = 1'b0;
        o_uart_wr    = 1'b0;
        o_uart_addr  = 4'd0;
        o_uart_wdata = 8'h00;
        case (state)
            RX_POLL: begin
                o_uart_en   = 1'b1;
                o_uart_addr = ADDR_RX_RDY;
            end
            RX_READ: begin
                o_uart_en   = 1'b1;
                o_uart_addr = ADDR_RX_DAT;
            end
            TX_POLL: begin
                o_uart_en   = 1'b1;
                o_uart_addr = ADDR_TX_RDY;
            end
            TX_WRITE: begin
                o_uart_en    = 1'b1;
                o_uart_wr    = 1'b1;
                o_uart_addr  = ADDR_TX_DAT;
                o_uart_wdata = tx_head;
            end
            default: ;
        endcase
    end

endmodule
